// File: rtl/miniram_fill_ctrl.sv
// Line-fill arbiter/streamer between the I/D cache miss handlers and the 16 x 256-bit miniram.
// Define CRITICAL_WORD_FIRST_EN to start each burst at the requested word (addr[4:2]) instead of word 0.
module miniram_fill_ctrl #(
    parameter int unsigned ROM_LAT = 1
) (
    input  logic         nGCLK,
    input  logic         RESET,
    input  logic         ireq,
    input  logic [31:0]  iaddr,
    input  logic         dreq,
    input  logic [31:0]  daddr,
    output logic         igrant,
    output logic         dgrant,
    output logic [3:0]   ram_sel,
    input  logic [255:0] ram_data,
    output logic         fill_valid,
    input  logic         fill_ready,
    output logic [31:0]  fill_data,
    output logic [2:0]   fill_wadr,
    output logic         fill_last,
    output logic         fill_src,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_e;

    state_e         state_q, state_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [2:0]     beat_q, beat_d;
    logic [2:0]     start_q, start_d;
    logic [255:0]   line_q, line_d;
    logic           rr_d_q, rr_d_d;      // 1: next contested grant goes to D
    logic           igrant_q, igrant_d;
    logic           dgrant_q, dgrant_d;
    logic [3:0]     ram_sel_q, ram_sel_d;
    logic           fill_valid_q, fill_valid_d;
    logic [31:0]    fill_data_q, fill_data_d;
    logic [2:0]     fill_wadr_q, fill_wadr_d;
    logic           fill_last_q, fill_last_d;
    logic           fill_src_q, fill_src_d;
    logic           busy_q, busy_d;

    logic           unused_addr_bits;
    assign unused_addr_bits = ^{iaddr, daddr};

    always_comb begin
        logic        pick_d;
        logic [31:0] sel_addr;
        logic [2:0]  next_w;

        state_d      = state_q;
        cnt_d        = cnt_q;
        beat_d       = beat_q;
        start_d      = start_q;
        line_d       = line_q;
        rr_d_d       = rr_d_q;
        igrant_d     = 1'b0;
        dgrant_d     = 1'b0;
        ram_sel_d    = ram_sel_q;
        fill_valid_d = fill_valid_q;
        fill_data_d  = fill_data_q;
        fill_wadr_d  = fill_wadr_q;
        fill_last_d  = fill_last_q;
        fill_src_d   = fill_src_q;
        pick_d       = 1'b0;
        sel_addr     = '0;
        next_w       = '0;

        case (state_q)
            IDLE: begin
                if (ireq || dreq) begin
                    pick_d   = dreq && (!ireq || rr_d_q);
                    sel_addr = pick_d ? daddr : iaddr;
                    if (ireq && dreq)
                        rr_d_d = !pick_d;
                    igrant_d   = !pick_d;
                    dgrant_d   = pick_d;
                    ram_sel_d  = sel_addr[8:5];
                    fill_src_d = pick_d;
                    cnt_d      = 3'(ROM_LAT);
`ifdef CRITICAL_WORD_FIRST_EN
                    start_d    = sel_addr[4:2];
`else
                    start_d    = '0;
`endif
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    line_d       = ram_data;
                    fill_valid_d = 1'b1;
                    fill_data_d  = ram_data[{start_q, 5'd0} +: 32];
                    fill_wadr_d  = start_q;
                    fill_last_d  = 1'b0;
                    beat_d       = '0;
                    state_d      = BURST;
                end
            end
            BURST: begin
                if (fill_ready) begin
                    if (beat_q == 3'd7) begin
                        fill_valid_d = 1'b0;
                        fill_last_d  = 1'b0;
                        state_d      = IDLE;
                    end else begin
                        // 3-bit add wraps the word index modulo 8
                        next_w      = start_q + beat_q + 3'd1;
                        beat_d      = beat_q + 3'd1;
                        fill_wadr_d = next_w;
                        fill_data_d = line_q[{next_w, 5'd0} +: 32];
                        fill_last_d = (beat_q == 3'd6);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge nGCLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            beat_q       <= '0;
            start_q      <= '0;
            line_q       <= '0;
            rr_d_q       <= 1'b1;
            igrant_q     <= 1'b0;
            dgrant_q     <= 1'b0;
            ram_sel_q    <= '0;
            fill_valid_q <= 1'b0;
            fill_data_q  <= '0;
            fill_wadr_q  <= '0;
            fill_last_q  <= 1'b0;
            fill_src_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            beat_q       <= beat_d;
            start_q      <= start_d;
            line_q       <= line_d;
            rr_d_q       <= rr_d_d;
            igrant_q     <= igrant_d;
            dgrant_q     <= dgrant_d;
            ram_sel_q    <= ram_sel_d;
            fill_valid_q <= fill_valid_d;
            fill_data_q  <= fill_data_d;
            fill_wadr_q  <= fill_wadr_d;
            fill_last_q  <= fill_last_d;
            fill_src_q   <= fill_src_d;
            busy_q       <= busy_d;
        end
    end

    assign igrant     = igrant_q;
    assign dgrant     = dgrant_q;
    assign ram_sel    = ram_sel_q;
    assign fill_valid = fill_valid_q;
    assign fill_data  = fill_data_q;
    assign fill_wadr  = fill_wadr_q;
    assign fill_last  = fill_last_q;
    assign fill_src   = fill_src_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_miniram_fill_ctrl.sv
// Directed, table-driven bench for miniram_fill_ctrl with a behavioural miniram contents table.
module tb_miniram_fill_ctrl;

    localparam int unsigned LAT = 1;

    logic         nGCLK = 1'b0;
    logic         RESET;
    logic         ireq, dreq;
    logic [31:0]  iaddr, daddr;
    logic         igrant, dgrant;
    logic [3:0]   ram_sel;
    logic [255:0] ram_data;
    logic         fill_valid, fill_ready;
    logic [31:0]  fill_data;
    logic [2:0]   fill_wadr;
    logic         fill_last, fill_src, busy;

    logic [31:0] rom [16][8];

    int total = 0;
    int bad = 0;

    typedef struct {
        bit          ireq;
        bit          dreq;
        logic [31:0] iaddr;
        logic [31:0] daddr;
        bit          exp_src;
        logic [3:0]  exp_line;
        logic [2:0]  exp_start;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
        int          stall_beat;
        int          stall_cyc;
    } vec_t;

    vec_t vecs[6];

    miniram_fill_ctrl #(.ROM_LAT(LAT)) dut (
        .nGCLK     (nGCLK),
        .RESET     (RESET),
        .ireq      (ireq),
        .iaddr     (iaddr),
        .dreq      (dreq),
        .daddr     (daddr),
        .igrant    (igrant),
        .dgrant    (dgrant),
        .ram_sel   (ram_sel),
        .ram_data  (ram_data),
        .fill_valid(fill_valid),
        .fill_ready(fill_ready),
        .fill_data (fill_data),
        .fill_wadr (fill_wadr),
        .fill_last (fill_last),
        .fill_src  (fill_src),
        .busy      (busy)
    );

    always #5 nGCLK = ~nGCLK;

    always_comb begin
        ram_data = '0;
        for (int k = 0; k < 8; k++)
            ram_data[k*32 +: 32] = rom[ram_sel][k];
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge nGCLK);
        #1;
    endtask

    task automatic run_burst(input vec_t v);
        bit got;
        int w;
        ireq  = v.ireq;
        dreq  = v.dreq;
        iaddr = v.iaddr;
        daddr = v.daddr;
        got = 0;
        for (int c = 0; c < 8 && !got; c++) begin
            step();
            if (igrant || dgrant) got = 1;
        end
        check("grant_seen", 32'(got), 32'd1);
        if (!got) begin
            ireq = 0;
            dreq = 0;
            return;
        end
        check("igrant", 32'(igrant), 32'(!v.exp_src));
        check("dgrant", 32'(dgrant), 32'(v.exp_src));
        check("ram_sel", 32'(ram_sel), 32'(v.exp_line));
        check("src_at_grant", 32'(fill_src), 32'(v.exp_src));
        check("busy_at_grant", 32'(busy), 32'd1);
        check("valid_at_grant", 32'(fill_valid), 32'd0);
        if (v.exp_src) dreq = 0; else ireq = 0;
        for (int k = 1; k <= int'(LAT); k++) begin
            step();
            if (k == 1) check("grant_pulse", 32'({igrant, dgrant}), 32'd0);
            check("latency_valid", 32'(fill_valid), 32'(k == int'(LAT)));
        end
        for (int n = 0; n < 8; n++) begin
            w = (int'(v.exp_start) + n) % 8;
            check("valid", 32'(fill_valid), 32'd1);
            check("wadr", 32'(fill_wadr), 32'(w));
            check("data", fill_data, rom[v.exp_line][w]);
            check("last", 32'(fill_last), 32'(n == 7));
            check("src", 32'(fill_src), 32'(v.exp_src));
            check("ram_sel_hold", 32'(ram_sel), 32'(v.exp_line));
            if (n == 0) check("first_data", fill_data, v.exp_first);
            if (n == 7) check("last_data", fill_data, v.exp_last);
            if (n == v.stall_beat) begin
                fill_ready = 0;
                for (int s = 0; s < v.stall_cyc; s++) begin
                    step();
                    check("stall_valid", 32'(fill_valid), 32'd1);
                    check("stall_wadr", 32'(fill_wadr), 32'(w));
                    check("stall_data", fill_data, rom[v.exp_line][w]);
                    check("stall_last", 32'(fill_last), 32'(n == 7));
                end
                fill_ready = 1;
            end
            step();
        end
        check("end_valid", 32'(fill_valid), 32'd0);
        check("end_last", 32'(fill_last), 32'd0);
        check("end_busy", 32'(busy), 32'd0);
        check("no_b2b_grant", 32'({igrant, dgrant}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        vec_t rv;
        for (int l = 0; l < 16; l++)
            for (int w = 0; w < 8; w++)
                rom[l][w] = 32'h5A00_0000 | (l << 8) | w;
        rom[0] = '{32'he3a0da01, 32'he1a0e00f, 32'he92d0f8f, 32'he24ee004,
                   32'he3a00000, 32'he59f1010, 32'he5810000, 32'hed2def01};
        rom[1] = '{32'he49d8004, 32'he3c8801f, 32'hea00000c, 32'he1a00000,
                   32'he1a00000, 32'he1a00000, 32'he1a00000, 32'he1a00000};

`ifdef CRITICAL_WORD_FIRST_EN
        vecs[0] = '{1, 0, 32'h0000_0020, 32'h0, 0, 4'd1, 3'd0, 32'he49d8004, 32'he1a00000, -1, 0};
        vecs[1] = '{1, 1, 32'hABCD_E03C, 32'h0000_000C, 1, 4'd0, 3'd3, 32'he24ee004, 32'he92d0f8f, -1, 0};
        vecs[2] = '{1, 0, 32'hABCD_E03C, 32'h0, 0, 4'd1, 3'd7, 32'he1a00000, 32'he1a00000, -1, 0};
        vecs[3] = '{1, 1, 32'hABCD_E03C, 32'h0000_000C, 0, 4'd1, 3'd7, 32'he1a00000, 32'he1a00000, -1, 0};
        vecs[4] = '{1, 1, 32'hABCD_E03C, 32'h0000_000C, 1, 4'd0, 3'd3, 32'he24ee004, 32'he92d0f8f, -1, 0};
`else
        vecs[0] = '{1, 0, 32'h0000_0020, 32'h0, 0, 4'd1, 3'd0, 32'he49d8004, 32'he1a00000, -1, 0};
        vecs[1] = '{1, 1, 32'hABCD_E03C, 32'h0000_000C, 1, 4'd0, 3'd0, 32'he3a0da01, 32'hed2def01, -1, 0};
        vecs[2] = '{1, 0, 32'hABCD_E03C, 32'h0, 0, 4'd1, 3'd0, 32'he49d8004, 32'he1a00000, -1, 0};
        vecs[3] = '{1, 1, 32'hABCD_E03C, 32'h0000_000C, 0, 4'd1, 3'd0, 32'he49d8004, 32'he1a00000, -1, 0};
        vecs[4] = '{1, 1, 32'hABCD_E03C, 32'h0000_000C, 1, 4'd0, 3'd0, 32'he3a0da01, 32'hed2def01, -1, 0};
`endif
        vecs[5] = '{0, 1, 32'h0, 32'hFFFF_FE03, 1, 4'd0, 3'd0, 32'he3a0da01, 32'hed2def01, 2, 3};

        RESET = 1; ireq = 0; dreq = 0; iaddr = '0; daddr = '0; fill_ready = 1;
        step();
        step();
        RESET = 0;
        step();
        RESET = 1;
        #1;
        check("rst_outputs", 32'({igrant, dgrant, fill_valid, fill_last, fill_src, busy}), 32'd0);
        check("rst_ram_sel", 32'(ram_sel), 32'd0);
        check("rst_fill_data", fill_data, 32'd0);
        check("rst_fill_wadr", 32'(fill_wadr), 32'd0);
        step();
        RESET = 0;
        step();
        check("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 6; i++)
            run_burst(vecs[i]);

        // Reset in the middle of a burst must abort it cleanly.
        ireq = 1; dreq = 0; iaddr = 32'h0000_0020;
        seen = 0;
        for (int c = 0; c < 8 && !seen; c++) begin
            step();
            if (igrant) seen = 1;
        end
        check("abort_grant", 32'(seen), 32'd1);
        ireq = 0;
        seen = 0;
        for (int c = 0; c < 8 && !seen; c++) begin
            step();
            if (fill_valid) seen = 1;
        end
        check("abort_valid_seen", 32'(seen), 32'd1);
        repeat (4) step();
        check("abort_beat4_wadr", 32'(fill_wadr), 32'd4);
        check("abort_beat4_valid", 32'(fill_valid), 32'd1);
        RESET = 1;
        #1;
        check("abort_valid", 32'(fill_valid), 32'd0);
        check("abort_last", 32'(fill_last), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ram_sel", 32'(ram_sel), 32'd0);
        seen = 0;
        repeat (3) begin
            step();
            if (fill_last || fill_valid) seen = 1;
        end
        check("abort_quiet", 32'(seen), 32'd0);
        RESET = 0;
        rv = '{1, 0, 32'h0000_0020, 32'h0, 0, 4'd1, 3'd0, 32'he49d8004, 32'he1a00000, -1, 0};
        run_burst(rv);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
